// File: rtl/write_ack_gen_pkg.sv
// Shared constants and types for the AXI write-acknowledge generator.
// Holds the default AXI write-ID width and the ID queue depth.
package write_ack_gen_pkg;

    localparam int unsigned AXI_ID_WIDTH = 4;
    localparam int unsigned WACK_DEPTH   = 16;

    typedef enum logic {
        OUT_IDLE  = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/wack_id_ring.sv
// In-order ring buffer of accepted AW IDs: push at the tail, pop from the head.
// A push into a full ring is dropped and leaves the ring unchanged.
module wack_id_ring #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ID_WIDTH-1:0]      push_id,
    input  logic                     pop,
    output logic [ID_WIDTH-1:0]      head_id,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push_ok;
    logic                pop_ok;

    assign push_ok = push & (count != CW'(DEPTH));
    assign pop_ok  = pop & (count != '0);
    assign head_id = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/write_ack_gen.sv
// Generates AXI B responses in AW order, one per committed write (credit).
// Optional sticky error flag err_o is built only with WACK_ERR_CHECK_EN defined.
module write_ack_gen
    import write_ack_gen_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = AXI_ID_WIDTH,
    parameter int unsigned DEPTH     = WACK_DEPTH,
    parameter int unsigned AFULL_THR = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aw_push_i,
    input  logic [ID_WIDTH-1:0]      aw_id_i,
    output logic                     afull_o,
    input  logic                     wr_done_i,
    output logic [ID_WIDTH-1:0]      bid_o,
    output logic                     bvalid_o,
    input  logic                     bready_i,
    output logic [$clog2(DEPTH):0]   pending_o
`ifdef WACK_ERR_CHECK_EN
    ,
    output logic                     err_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]       count;
    logic [CW-1:0]       credit;
    logic [ID_WIDTH-1:0] head_id;
    out_state_e          state;
    out_state_e          state_n;
    logic                done_ok_c;
    logic                load_c;

    wack_id_ring #(
        .ID_WIDTH (ID_WIDTH),
        .DEPTH    (DEPTH)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .push    (aw_push_i),
        .push_id (aw_id_i),
        .pop     (load_c),
        .head_id (head_id),
        .count   (count)
    );

    // Credits never exceed queued IDs; a same-cycle done bypasses into the load
    assign done_ok_c = wr_done_i & (credit != count);
    assign load_c    = ((state == OUT_IDLE) | bready_i) & (count != '0)
                     & ((credit != '0) | done_ok_c);

    assign bvalid_o  = (state == OUT_VALID);
    assign afull_o   = (count >= CW'(AFULL_THR));
    assign pending_o = count + CW'(bvalid_o);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OUT_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (load_c) begin
            state_n = OUT_VALID;
        end else if ((state == OUT_VALID) && bready_i) begin
            state_n = OUT_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bid_o  <= '0;
            credit <= '0;
        end else begin
            if (load_c) begin
                bid_o <= head_id;
            end
            case ({done_ok_c, load_c})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

`ifdef WACK_ERR_CHECK_EN
    logic drop_c;
    logic ignore_c;

    assign drop_c   = aw_push_i & (count == CW'(DEPTH));
    assign ignore_c = wr_done_i & (credit == count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (drop_c || ignore_c) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_write_ack_gen.sv
// Scoreboard bench for write_ack_gen: expected B IDs queued at AW push,
// popped and compared by a monitor on every B handshake.
module tb_write_ack_gen;

    logic       clk;
    logic       rst;
    logic       aw_push;
    logic [3:0] aw_id;
    logic       afull;
    logic       wr_done;
    logic [3:0] bid;
    logic       bvalid;
    logic       bready;
    logic [4:0] pending;
`ifdef WACK_ERR_CHECK_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] sb [$];

    write_ack_gen #(
        .ID_WIDTH  (4),
        .DEPTH     (16),
        .AFULL_THR (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .aw_push_i (aw_push),
        .aw_id_i   (aw_id),
        .afull_o   (afull),
        .wr_done_i (wr_done),
        .bid_o     (bid),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .pending_o (pending)
`ifdef WACK_ERR_CHECK_EN
        ,
        .err_o     (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_id(input logic [3:0] id, input bit expect_b);
        aw_push = 1'b1;
        aw_id   = id;
        if (expect_b) sb.push_back(id);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (pending != 0 && n < 60) begin
            tick();
            n++;
        end
        chk(name, int'(pending), 0);
    endtask

    // Monitor: a handshake completes at the next rising edge
    always @(negedge clk) begin
        if (!rst && bvalid && bready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_b actual_bid=%0d expected=none", bid);
            end else begin
                chk("bid_order", int'(bid), int'(sb.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        aw_push = 1'b0;
        aw_id   = '0;
        wr_done = 1'b0;
        bready  = 1'b0;
        tick();
        tick();
        chk("rst_bvalid",  int'(bvalid),  0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_afull",   int'(afull),   0);
        chk("rst_bid",     int'(bid),     0);
        rst = 1'b0;
        tick();

        // Three IDs, three commits, back-to-back responses
        bready = 1'b1;
        push_id(4'd3, 1'b1); tick();
        push_id(4'd5, 1'b1); tick();
        push_id(4'd9, 1'b1); tick();
        aw_push = 1'b0;
        wr_done = 1'b1;
        chk("lat_before", int'(bvalid), 0);
        tick();
        chk("lat_bvalid", int'(bvalid), 1);
        chk("lat_pending", int'(pending), 3);
        tick();
        chk("b2b_1", int'(bvalid), 1);
        tick();
        chk("b2b_2", int'(bvalid), 1);
        wr_done = 1'b0;
        tick();
        chk("b2b_drop", int'(bvalid), 0);
        wait_empty("drain_a");

        // Back-pressure hold
        bready = 1'b0;
        push_id(4'd7, 1'b1); tick();
        aw_push = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("hold_bvalid", int'(bvalid), 1);
            chk("hold_bid", int'(bid), 7);
            chk("hold_pending", int'(pending), 1);
            tick();
        end
        bready = 1'b1;
        chk("hs_pending_pre", int'(pending), 1);
        tick();
        chk("hs_bvalid_post", int'(bvalid), 0);
        chk("hs_pending_post", int'(pending), 0);

        // Fill to full, overflow push dropped
        for (int i = 0; i < 17; i++) begin
            push_id(4'(i), i < 16);
            tick();
            chk("afull", int'(afull), ((i + 1) >= 14) ? 1 : 0);
        end
        aw_push = 1'b0;
        chk("full_pending", int'(pending), 16);
        chk("full_nob", int'(bvalid), 0);
`ifdef WACK_ERR_CHECK_EN
        chk("err_drop", int'(err), 1);
`endif
        wr_done = 1'b1;
        repeat (16) tick();
        wr_done = 1'b0;
        wait_empty("drain_full");

        // Commit with nothing queued is ignored
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("empty_done_bvalid", int'(bvalid), 0);
        chk("empty_done_pending", int'(pending), 0);
`ifdef WACK_ERR_CHECK_EN
        chk("err_ignore", int'(err), 1);
`endif
        push_id(4'd4, 1'b1); tick();
        aw_push = 1'b0;
        repeat (3) tick();
        chk("no_credit_bvalid", int'(bvalid), 0);
        chk("no_credit_pending", int'(pending), 1);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("credit_bvalid", int'(bvalid), 1);
        wait_empty("drain_credit");

        // Steady stream with pointer wrap
        push_id(4'd10, 1'b1); tick();
        for (int i = 0; i < 40; i++) begin
            push_id(4'(i * 7 + 1), 1'b1);
            wr_done = 1'b1;
            tick();
            chk("stream_pending", int'(pending), 2);
        end
        aw_push = 1'b0;
        tick();
        wr_done = 1'b0;
        wait_empty("drain_stream");

        // Reset mid-operation
        bready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_id(4'(11 + i), 1'b0);
            tick();
        end
        aw_push = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("pre_rst_bvalid", int'(bvalid), 1);
        chk("pre_rst_pending", int'(pending), 6);
        rst = 1'b1;
        #1;
        chk("async_rst_bvalid", int'(bvalid), 0);
        chk("async_rst_pending", int'(pending), 0);
        chk("async_rst_bid", int'(bid), 0);
        tick();
        tick();
        rst = 1'b0;
        bready = 1'b1;
        push_id(4'd2, 1'b1); tick();
        aw_push = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        chk("post_rst_bvalid", int'(bvalid), 1);
        chk("post_rst_bid", int'(bid), 2);
        wait_empty("drain_post_rst");

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
